// File: rtl/ram_seq_pkg.sv
// ram_seq_pkg: shared state encoding and default sizes for the RAM burst sequencer.
// Contents: state_t (IDLE, WR, RD_REQ, RD_CAP, RD_OUT), DATA_W_DEF, ADDR_W_DEF.
package ram_seq_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 6;
    typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_CAP, RD_OUT} state_t;
endpackage

// File: rtl/ram_seq_cnt.sv
// ram_seq_cnt: burst address counter with saturating length latch and last-word flag.
// Ports: clk, rst (async, active-high), clear (restart at 0 and latch len), inc (advance),
//        len [ADDR_W:0] burst length, addr [ADDR_W-1:0] current RAM address,
//        last (current word is the final one of the burst).
module ram_seq_cnt
    import ram_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              inc,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);
    logic [ADDR_W:0] count;
    logic [ADDR_W:0] len_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            len_q <= '0;
        end else if (clear) begin
            count <= '0;
            len_q <= len > DEPTH ? DEPTH : len;
        end else if (inc) begin
            count <= count + ONE;
        end
    end
    // Counter is one bit wider than the address so a full-depth burst
    // finishes on address DEPTH-1 without aliasing back to 0.
    assign last = (count + ONE) == len_q;
    assign addr = count[ADDR_W-1:0];
endmodule

// File: rtl/ram_seq_ctrl.sv
// ram_seq_ctrl: write/read burst sequencer in front of a single-port RAM with 1-cycle read latency.
// Ports: clk, rst (async, active-high); start_wr/start_rd/len burst request; in_data/in_valid/in_ready
//        write stream; out_data/out_valid/out_ready read stream; busy, done status;
//        ram_data/ram_addr/ram_we/ram_q RAM side.
// Option: define RAM_SEQ_CHKSUM_EN to add output chksum, the running sum of words moved in the burst.
module ram_seq_ctrl
    import ram_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_wr,
    input  logic              start_rd,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
`ifdef RAM_SEQ_CHKSUM_EN
    ,
    output logic [DATA_W-1:0] chksum
`endif
);
    state_t state, state_nx;
    logic   last;
    logic   accept, wr_beat, rd_beat, fin;

    assign accept  = state == IDLE && (start_wr || start_rd);
    assign wr_beat = state == WR && in_valid;
    assign rd_beat = state == RD_OUT && out_ready;
    // A zero-length start finishes immediately without leaving IDLE.
    assign fin     = ((wr_beat || rd_beat) && last) || (accept && len == '0);

    ram_seq_cnt #(.ADDR_W(ADDR_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .inc   (wr_beat || rd_beat),
        .len   (len),
        .addr  (ram_addr),
        .last  (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && len != '0) state_nx = start_wr ? WR : RD_REQ;
            WR:      if (wr_beat && last) state_nx = IDLE;
            RD_REQ:  state_nx = RD_CAP;
            RD_CAP:  state_nx = RD_OUT;
            RD_OUT:  if (out_ready) state_nx = last ? IDLE : RD_REQ;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state == WR;
        ram_we    = state == WR && in_valid;
        ram_data  = state == WR ? in_data : '0;
        out_valid = state == RD_OUT;
        busy      = state != IDLE;
    end

    // ram_q reflects the address presented in RD_REQ, so it is captured in RD_CAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            done     <= 1'b0;
        end else begin
            done <= fin;
            if (state == RD_CAP) out_data <= ram_q;
        end
    end

`ifdef RAM_SEQ_CHKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          chksum <= '0;
        else if (accept)  chksum <= '0;
        else if (wr_beat) chksum <= chksum + in_data;
        else if (rd_beat) chksum <= chksum + out_data;
    end
`endif
endmodule

// File: tb/tb_ram_seq_ctrl.sv
// tb_ram_seq_ctrl: scoreboard bench for ram_seq_ctrl with a behavioural RAM and reference memory image.
module tb_ram_seq_ctrl;
    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk = 0;
    logic          rst, start_wr, start_rd, in_valid, out_ready;
    logic [AW:0]   len;
    logic [DW-1:0] in_data, out_data, ram_data, ram_q;
    logic [AW-1:0] ram_addr;
    logic          in_ready, out_valid, busy, done, ram_we;
`ifdef RAM_SEQ_CHKSUM_EN
    logic [DW-1:0] chksum;
`endif

    ram_seq_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_wr  (start_wr),
        .start_rd  (start_rd),
        .len       (len),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .ram_data  (ram_data),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
`ifdef RAM_SEQ_CHKSUM_EN
        .chksum    (chksum),
`endif
        .ram_q     (ram_q)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [64];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    logic [DW-1:0]    ref_mem [64];
    logic [AW+DW-1:0] wq [$];
    logic [DW-1:0]    rq [$];
    logic [DW-1:0]    dq [$];
    int vecs = 0, errs = 0;
    int done_cnt = 0, rd_idx = 0, cyc = 0, last_hs = 0;
    bit chk_rate = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (ram_we) begin
                vecs++;
                if (wq.size() == 0) begin
                    errs++; $display("FAIL wr_unexpected addr=%0d data=%0h", ram_addr, ram_data);
                end else begin
                    logic [AW+DW-1:0] e;
                    e = wq.pop_front();
                    if ({ram_addr, ram_data} !== e) begin
                        errs++; $display("FAIL wr addr/data got %0d/%0h exp %0d/%0h", ram_addr, ram_data, e[AW+DW-1:DW], e[DW-1:0]);
                    end
                end
            end
            if (out_valid && out_ready) begin
                vecs++;
                if (rq.size() == 0) begin
                    errs++; $display("FAIL rd_unexpected data=%0h", out_data);
                end else begin
                    logic [DW-1:0] e;
                    e = rq.pop_front();
                    if (out_data !== e) begin
                        errs++; $display("FAIL rd word %0d got %0h exp %0h", rd_idx, out_data, e);
                    end
                end
                if (chk_rate && rd_idx > 0) begin
                    vecs++;
                    if (cyc - last_hs != 3) begin
                        errs++; $display("FAIL rd_rate spacing got %0d exp 3", cyc - last_hs);
                    end
                end
                last_hs = cyc;
                rd_idx++;
            end
            if (done) begin
                vecs++;
                if (dq.size() == 0) begin
                    errs++; $display("FAIL done_unexpected at cycle %0d", cyc);
                end else begin
                    logic [DW-1:0] e;
                    e = dq.pop_front();
`ifdef RAM_SEQ_CHKSUM_EN
                    if (chksum !== e) begin
                        errs++; $display("FAIL chksum got %0h exp %0h", chksum, e);
                    end
`endif
                end
                done_cnt++;
            end
        end
    end

    task automatic wait_done(input int tgt);
        for (int k = 0; k < 200 && done_cnt < tgt; k++) @(negedge clk);
        vecs++;
        if (done_cnt != tgt) begin
            errs++; $display("FAIL done_timeout got %0d exp %0d", done_cnt, tgt);
        end
    endtask

    task automatic do_write(input int l, input bit gaps, input bit both, input int base, input bit rnd);
        int n, i, tgt;
        logic [DW-1:0] dat [64];
        logic [DW-1:0] sum;
        n = l > 64 ? 64 : l;
        i = 0;
        sum = '0;
        for (int k = 0; k < n; k++) begin
            dat[k] = rnd ? DW'($urandom) : DW'(base + k);
            sum += dat[k];
        end
        @(posedge clk); #1;
        dq.push_back(sum);
        tgt = done_cnt + 1;
        start_wr = 1; start_rd = both; len = (AW+1)'(l);
        @(posedge clk); #1;
        start_wr = 0; start_rd = 0;
        if (n == 0) begin
            vecs++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                errs++; $display("FAIL len0 done/busy got %b/%b exp 1/0", done, busy);
            end
        end
        while (i < n) begin
            bit v;
            v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            vecs++;
            if (in_ready !== 1'b1) begin
                errs++; $display("FAIL in_ready got %b exp 1", in_ready);
            end
            start_rd = $urandom_range(0, 7) == 0;
            len = (AW+1)'($urandom_range(0, 100));
            in_valid = v;
            in_data = v ? dat[i] : DW'($urandom);
            if (v) begin
                wq.push_back({AW'(i), dat[i]});
                ref_mem[i] = dat[i];
                i++;
            end
            @(posedge clk); #1;
        end
        in_valid = 0; start_rd = 0;
        wait_done(tgt);
    endtask

    task automatic do_read(input int l, input int stall_w, input int stall_n, input bit rnd_rdy, input bit rate);
        int n, tgt, left;
        logic [DW-1:0] sum;
        n = l > 64 ? 64 : l;
        left = stall_n;
        sum = '0;
        @(posedge clk); #1;
        rd_idx = 0; chk_rate = rate;
        for (int k = 0; k < n; k++) begin
            rq.push_back(ref_mem[k]);
            sum += ref_mem[k];
        end
        dq.push_back(sum);
        tgt = done_cnt + 1;
        start_rd = 1; len = (AW+1)'(l); out_ready = 1;
        @(posedge clk); #1;
        start_rd = 0;
        for (int c = 0; c < 3000 && done_cnt < tgt; c++) begin
            if (out_valid && rd_idx == stall_w && left > 0) begin
                out_ready = 0;
                left--;
                vecs++;
                if (out_data !== ref_mem[stall_w] || ram_addr !== AW'(stall_w)) begin
                    errs++; $display("FAIL stall data/addr got %0h/%0d exp %0h/%0d", out_data, ram_addr, ref_mem[stall_w], stall_w);
                end
            end else begin
                out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            @(posedge clk); #1;
        end
        vecs++;
        if (done_cnt != tgt || left != 0) begin
            errs++; $display("FAIL rd_timeout done %0d exp %0d stall_left %0d", done_cnt, tgt, left);
        end
        chk_rate = 0;
        out_ready = 0;
    endtask

    initial begin
        for (int k = 0; k < 64; k++) begin
            mem[k] = '0;
            ref_mem[k] = '0;
        end
        rst = 1; start_wr = 0; start_rd = 0; len = '0;
        in_data = '0; in_valid = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        vecs++;
        if ({ram_we, ram_addr, ram_data, out_data, out_valid, in_ready, busy, done} !== '0) begin
            errs++; $display("FAIL reset_outputs got %0h exp 0", {ram_we, ram_addr, ram_data, out_data, out_valid, in_ready, busy, done});
        end
        rst = 0;

        do_write(5, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            vecs++;
            if (mem[k] !== DW'(k)) begin
                errs++; $display("FAIL ram_content[%0d] got %0h exp %0h", k, mem[k], k);
            end
        end
        do_read(5, -1, 0, 0, 1);
        do_read(5, 2, 4, 0, 0);

        do_write(6, 0, 1, 40, 0);
        do_read(6, -1, 0, 0, 1);
        do_write(0, 0, 0, 0, 0);
        do_write(0, 0, 1, 0, 0);
        do_read(0, -1, 0, 0, 0);

        do_write(64, 1, 0, 0, 1);
        do_read(64, -1, 0, 1, 0);
        do_write(100, 0, 0, 100, 0);
        vecs++;
        if (mem[63] !== DW'(163) || mem[0] !== DW'(100)) begin
            errs++; $display("FAIL len100_ends got %0h/%0h exp 64/a3", mem[0], mem[63]);
        end
        do_read(100, -1, 0, 0, 1);

        @(posedge clk); #1;
        start_wr = 1; len = 8;
        @(posedge clk); #1;
        start_wr = 0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1; in_data = DW'(200 + k);
            wq.push_back({AW'(k), DW'(200 + k)});
            ref_mem[k] = DW'(200 + k);
            @(posedge clk); #1;
        end
        in_data = 203;
        rst = 1;
        #1;
        vecs++;
        if ({ram_we, ram_addr, ram_data, out_data, out_valid, in_ready, busy, done} !== '0) begin
            errs++; $display("FAIL midburst_reset got %0h exp 0", {ram_we, ram_addr, ram_data, out_data, out_valid, in_ready, busy, done});
        end
        in_valid = 0;
        @(posedge clk); #1;
        rst = 0;
        do_read(8, -1, 0, 0, 1);

        for (int b = 0; b < 20; b++) begin
            if ($urandom_range(0, 1) != 0) do_write($urandom_range(0, 100), 1, $urandom_range(0, 1) != 0, 0, 1);
            else do_read($urandom_range(0, 100), $urandom_range(0, 10), $urandom_range(0, 3), 1, 0);
        end

        repeat (3) @(posedge clk);
        vecs++;
        if (wq.size() != 0 || rq.size() != 0 || dq.size() != 0) begin
            errs++; $display("FAIL leftover_expect wr %0d rd %0d done %0d exp 0", wq.size(), rq.size(), dq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/ram_seq_ctrl.md
RAM_SEQ_CTRL -- requirements
Module: ram_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning RAM word width.
REQ-002 SHALL have parameter ADDR_W, default 6, meaning RAM address width (depth 2**ADDR_W = 64).
REQ-003 SHALL have port clk  input  1  rising-edge clock (single clock domain).
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start_wr  input  1  one-cycle request to begin a write burst.
REQ-006 SHALL have port start_rd  input  1  one-cycle request to begin a read burst.
REQ-007 SHALL have port len  input  ADDR_W+1  burst length in words, sampled on the accepted start.
REQ-008 SHALL have port in_data  input  DATA_W  write-stream data.
REQ-009 SHALL have port in_valid  input  1  write-stream valid.
REQ-010 SHALL have port in_ready  output  1  write-stream ready.
REQ-011 SHALL have port out_data  output  DATA_W  read-stream data (registered).
REQ-012 SHALL have port out_valid  output  1  read-stream valid.
REQ-013 SHALL have port out_ready  input  1  read-stream ready.
REQ-014 SHALL have port busy  output  1  high while not IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at burst end.
REQ-016 SHALL have ports ram_data (output, DATA_W), ram_addr (output, ADDR_W) and ram_we (output, 1), which drive single_port_ram data/addr/we.
REQ-017 SHALL have port ram_q  input  DATA_W  single_port_ram q, valid one clk after ram_addr is presented.

Function
REQ-018 SHALL implement FSM states IDLE, WR, RD_REQ, RD_CAP, RD_OUT.
REQ-019 In IDLE, start_wr SHALL go to WR; otherwise start_rd SHALL go to RD_REQ; start_wr SHALL win when both are asserted together.
REQ-020 Starts SHALL be ignored outside IDLE.
REQ-021 An accepted start SHALL clear the address counter to 0 and latch len; len values >64 SHALL saturate to 64.
REQ-022 len=0 SHALL cause no RAM access, and done SHALL pulse the cycle after the start, with the FSM remaining in IDLE.
REQ-023 In WR, in_ready SHALL be 1, and ram_we SHALL equal in_valid combinationally, with ram_data=in_data and ram_addr=counter.
REQ-024 In WR, each in_valid cycle SHALL increment the counter.
REQ-025 In WR, after the len-th accepted word the FSM SHALL return to IDLE and done SHALL pulse the next cycle.
REQ-026 A read SHALL take three states per word: RD_REQ (present ram_addr), then RD_CAP (out_data<=ram_q, out_valid<=1), then RD_OUT (hold out_data and out_valid until out_ready).
REQ-027 On the out_ready handshake in RD_OUT, the FSM SHALL increment the counter and go to RD_REQ, or to IDLE with done after the len-th word.
REQ-028 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 ram_we SHALL be 0 in every state except WR.
REQ-030 The address counter SHALL be ADDR_W+1 bits, with ram_addr taken from its low ADDR_W bits; len=64 SHALL end at address 63 without wrapping.
REQ-031 in_ready SHALL be 0 outside WR, and out_valid SHALL be 0 outside RD_OUT.

Reset
REQ-032 On rst, the block SHALL go immediately to IDLE, mid-burst included.
REQ-033 On rst, the counter SHALL be 0 and all outputs SHALL be 0: ram_we, ram_addr, ram_data, out_data, out_valid, in_ready, busy, done.
REQ-034 After rst deasserts, the next accepted start SHALL begin a fresh burst; the partial burst SHALL NOT be resumed.

Configuration
REQ-035 With macro RAM_SEQ_CHKSUM_EN defined, the block SHALL add output chksum (DATA_W), the modulo-2**DATA_W sum of all words written or delivered in the current burst.
REQ-036 With RAM_SEQ_CHKSUM_EN defined, chksum SHALL clear on an accepted start and on rst, and SHALL be stable when done pulses.
REQ-037 Without RAM_SEQ_CHKSUM_EN, the chksum port and its logic SHALL be absent.

Structure
REQ-038 A shared package ram_seq_pkg SHALL hold the FSM state typedef and the DATA_W/ADDR_W default constants.
REQ-039 The address/length counter SHALL be a single sub-module ram_seq_cnt (clear, increment, last-word flag).

Verification
REQ-040 Bench SHALL cover: start_wr, len=5, in_data 0..4 with in_valid held high -> ram_we high 5 cycles at addr 0..4, then done pulse, and single_port_ram holds 0..4.
REQ-041 Bench SHALL cover: start_rd, len=5 after REQ-040, out_ready=1 -> out_data 0,1,2,3,4 in order, one word per 3 cycles, then done pulse.
REQ-042 Bench SHALL cover: out_ready=0 for 4 cycles on word 2 -> out_data=2 held with out_valid=1 and no address advance.
REQ-043 Bench SHALL cover: start_wr and start_rd in the same cycle -> write burst taken; len=0 -> done next cycle and ram_we never high.
REQ-044 Bench SHALL cover: len=64 write then read -> addresses 0..63 with no wrap; len=100 behaves identically to 64.
REQ-045 Bench SHALL cover: rst asserted mid-write at word 3 -> outputs 0 in the same cycle, busy=0, and words 3+ not written.
